// File: rtl/fp51_inst_mem_loader.sv
`timescale 1ns/1ps
// fp51_inst_mem_loader
// Host-side framed loader/reader for the FP51 instruction memory.
// Frame: SYNC, CMD, ADDR_H, ADDR_L, LEN, [4*LEN data bytes, LSB first], CSUM.
// Optional inter-byte timeout is compiled in with FP51_LOADER_TIMEOUT_EN.
module fp51_inst_mem_loader #(
  parameter int          PC_BITWIDTH    = 16,
  parameter logic [7:0]  SYNC_BYTE      = 8'h5A,
  parameter int          TIMEOUT_CYCLES = 1000000
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  output logic                   inst_mem_we,
  output logic [PC_BITWIDTH-3:0] inst_mem_wr_addr,
  output logic [31:0]            inst_mem_data_in,
  output logic                   inst_mem_re,
  output logic [PC_BITWIDTH-1:0] inst_mem_re_addr,
  input  logic                   inst_mem_re_enable_out,
  input  logic [31:0]            inst_mem_data_out,
  output logic                   loader_busy,
  output logic                   rx_overrun
);

  localparam int AW = PC_BITWIDTH - 2;

  typedef enum logic [3:0] {
    S_IDLE, S_CMD, S_ADDR_H, S_ADDR_L, S_LEN, S_WDATA, S_CSUM,
    S_RD_REQ, S_RD_WAIT, S_RD_SEND, S_RESP
  } state_t;

  state_t          state, state_nx;
  logic [AW-1:0]   addr;
  logic [7:0]      addr_hi;
  logic [8:0]      words_left;
  logic [1:0]      byte_idx;
  logic [23:0]     wbuf;
  logic [31:0]     rbuf;
  logic [7:0]      rx_sum;
  logic [7:0]      tx_sum;
  logic            is_write;
  logic            resp_pend;
  logic            tx_load;
  logic [7:0]      tx_byte;

  logic       rx_open, in_frame, rx_acc, rx_drop, tx_free, words_last, cmd_ok;
  logic [7:0] sum_chk, rd_byte;
  logic       to_hit;

  assign rx_open    = state inside {S_IDLE, S_CMD, S_ADDR_H, S_ADDR_L, S_LEN, S_WDATA, S_CSUM};
  assign in_frame   = state inside {S_CMD, S_ADDR_H, S_ADDR_L, S_LEN, S_WDATA, S_CSUM};
  assign tx_free    = !tx_valid;
  assign rx_acc     = rx_valid && tx_free && rx_open;
  assign rx_drop    = rx_valid && !rx_acc;
  assign words_last = (words_left == 9'd1);
  assign cmd_ok     = (rx_data == 8'h01) || (rx_data == 8'h02);
  assign sum_chk    = rx_sum + rx_data;
  assign rd_byte    = rbuf[{byte_idx, 3'b000} +: 8];
  assign inst_mem_re_addr = {addr, 2'b00};

`ifdef FP51_LOADER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt;

  // Inter-byte timer: restarts on every accepted byte, idle outside a frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                to_cnt <= '0;
    else if (!in_frame || rx_acc) to_cnt <= '0;
    else                         to_cnt <= to_cnt + TW'(1);
  end

  assign to_hit = in_frame && !rx_acc && (to_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  assign to_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  // Next-state logic; a timeout overrides any frame state.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:    if (rx_acc && rx_data == SYNC_BYTE) state_nx = S_CMD;
      S_CMD:     if (rx_acc) state_nx = cmd_ok ? S_ADDR_H : S_RESP;
      S_ADDR_H:  if (rx_acc) state_nx = S_ADDR_L;
      S_ADDR_L:  if (rx_acc) state_nx = S_LEN;
      S_LEN:     if (rx_acc) state_nx = is_write ? S_WDATA : S_CSUM;
      S_WDATA:   if (rx_acc && byte_idx == 2'd3 && words_last) state_nx = S_CSUM;
      S_CSUM:    if (rx_acc) state_nx = (!is_write && sum_chk == 8'h00) ? S_RD_REQ : S_RESP;
      S_RD_REQ:  state_nx = S_RD_WAIT;
      S_RD_WAIT: if (inst_mem_re_enable_out) state_nx = S_RD_SEND;
      S_RD_SEND: if (tx_free && byte_idx == 2'd3) state_nx = words_last ? S_RESP : S_RD_REQ;
      S_RESP:    if (!resp_pend && tx_valid && tx_ready) state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
    if (to_hit) state_nx = S_RESP;
  end

  // Outputs decoded from state, plus which byte (if any) enters the tx slot.
  always_comb begin
    loader_busy = (state != S_IDLE);
    inst_mem_re = (state == S_RD_REQ);
    tx_load     = 1'b0;
    tx_byte     = 8'h00;
    case (state)
      S_CMD:     if (rx_acc && !cmd_ok) begin tx_load = 1'b1; tx_byte = 8'hEE; end
      S_CSUM:    if (rx_acc) begin
                   tx_load = 1'b1;
                   tx_byte = (sum_chk == 8'h00) ? 8'hA5 : 8'hEE;
                 end
      S_RD_SEND: if (tx_free) begin tx_load = 1'b1; tx_byte = rd_byte; end
      S_RESP:    if (resp_pend && tx_free) begin tx_load = 1'b1; tx_byte = 8'h00 - tx_sum; end
      default:   ;
    endcase
    if (to_hit) begin
      tx_load = 1'b1;
      tx_byte = 8'hEE;
    end
  end

  // Single-entry tx slot: holds data/valid until the sink takes it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_valid <= 1'b0;
      tx_data  <= 8'h00;
    end else if (tx_load) begin
      tx_valid <= 1'b1;
      tx_data  <= tx_byte;
    end else if (tx_valid && tx_ready) begin
      tx_valid <= 1'b0;
    end
  end

  // Frame datapath: header capture, word assembly, write strobe, readback sequencing.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr             <= '0;
      addr_hi          <= 8'h00;
      words_left       <= 9'd0;
      byte_idx         <= 2'd0;
      wbuf             <= 24'h0;
      rbuf             <= 32'h0;
      rx_sum           <= 8'h00;
      tx_sum           <= 8'h00;
      is_write         <= 1'b0;
      resp_pend        <= 1'b0;
      inst_mem_we      <= 1'b0;
      inst_mem_wr_addr <= '0;
      inst_mem_data_in <= 32'h0;
      rx_overrun       <= 1'b0;
    end else begin
      inst_mem_we <= 1'b0;
      case (state)
        S_IDLE: if (rx_acc && rx_data == SYNC_BYTE) begin
          rx_sum     <= 8'h00;
          tx_sum     <= 8'h00;
          byte_idx   <= 2'd0;
          resp_pend  <= 1'b0;
          rx_overrun <= 1'b0;
        end
        S_CMD: if (rx_acc) begin
          is_write <= (rx_data == 8'h01);
          rx_sum   <= sum_chk;
        end
        S_ADDR_H: if (rx_acc) begin
          addr_hi <= rx_data;
          rx_sum  <= sum_chk;
        end
        S_ADDR_L: if (rx_acc) begin
          addr   <= AW'({addr_hi, rx_data});
          rx_sum <= sum_chk;
        end
        S_LEN: if (rx_acc) begin
          words_left <= (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
          rx_sum     <= sum_chk;
        end
        S_WDATA: if (rx_acc) begin
          rx_sum   <= sum_chk;
          byte_idx <= byte_idx + 2'd1;
          if (byte_idx == 2'd3) begin
            inst_mem_we      <= 1'b1;
            inst_mem_wr_addr <= addr;
            inst_mem_data_in <= {rx_data, wbuf};
            addr             <= addr + AW'(1);
            words_left       <= words_left - 9'd1;
          end else begin
            wbuf[{byte_idx, 3'b000} +: 8] <= rx_data;
          end
        end
        S_RD_WAIT: if (inst_mem_re_enable_out) rbuf <= inst_mem_data_out;
        S_RD_SEND: if (tx_free) begin
          tx_sum   <= tx_sum + rd_byte;
          byte_idx <= byte_idx + 2'd1;
          if (byte_idx == 2'd3) begin
            addr       <= addr + AW'(1);
            words_left <= words_left - 9'd1;
            if (words_last) resp_pend <= 1'b1;
          end
        end
        S_RESP: if (resp_pend && tx_free) resp_pend <= 1'b0;
        default: ;
      endcase
      if (rx_drop) rx_overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fp51_inst_mem_loader.sv
`timescale 1ns/1ps
// Directed bench for fp51_inst_mem_loader: write, read, bad checksum,
// bad command, wrap with LEN=0 and backpressure, reset abort, timeout.
module tb_fp51_inst_mem_loader;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic        inst_mem_we;
  logic [13:0] inst_mem_wr_addr;
  logic [31:0] inst_mem_data_in;
  logic        inst_mem_re;
  logic [15:0] inst_mem_re_addr;
  logic        inst_mem_re_enable_out = 1'b0;
  logic [31:0] inst_mem_data_out = 32'h0;
  logic        loader_busy;
  logic        rx_overrun;

  always #5 clk = ~clk;

  fp51_inst_mem_loader #(.PC_BITWIDTH(16), .SYNC_BYTE(8'h5A), .TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .reset_n(reset_n),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .inst_mem_we(inst_mem_we), .inst_mem_wr_addr(inst_mem_wr_addr),
    .inst_mem_data_in(inst_mem_data_in),
    .inst_mem_re(inst_mem_re), .inst_mem_re_addr(inst_mem_re_addr),
    .inst_mem_re_enable_out(inst_mem_re_enable_out),
    .inst_mem_data_out(inst_mem_data_out),
    .loader_busy(loader_busy), .rx_overrun(rx_overrun)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct { logic [13:0] a; logic [31:0] d; } wr_t;
  logic [7:0]  txq[$];
  wr_t         wrq[$];
  logic [15:0] req[$];
  logic [31:0] mem [int];

  // Observe accepted tx bytes and memory strobes between clock edges.
  always @(negedge clk) begin
    if (tx_valid && tx_ready) txq.push_back(tx_data);
    if (inst_mem_we) begin
      wrq.push_back('{a: inst_mem_wr_addr, d: inst_mem_data_in});
      mem[int'(inst_mem_wr_addr)] = inst_mem_data_in;
    end
    if (inst_mem_re) req.push_back(inst_mem_re_addr);
  end

  // Memory read responder: data valid two cycles after the request.
  initial begin : mem_resp
    int w;
    forever begin
      @(negedge clk);
      if (inst_mem_re) begin
        w = int'(inst_mem_re_addr[15:2]);
        @(posedge clk);
        @(posedge clk);
        #1;
        inst_mem_data_out = mem.exists(w) ? mem[w] : 32'hDEADBEEF;
        inst_mem_re_enable_out = 1'b1;
        @(posedge clk);
        #1;
        inst_mem_re_enable_out = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // All main-flow tasks start and end at posedge+1.
  task automatic send(input logic [7:0] b);
    rx_data = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] f[$]);
    foreach (f[i]) send(f[i]);
  endtask

  task automatic wait_tx(input string tag, input int n, input int budget);
    for (int i = 0; i < budget && txq.size() < n; i++) begin
      @(posedge clk);
      #1;
    end
    check({tag, " tx count"}, txq.size(), n);
  endtask

  task automatic clear_logs();
    txq.delete();
    wrq.delete();
    req.delete();
  endtask

  initial begin : main
    logic [7:0]  f[$];
    logic [7:0]  sum;
    logic [31:0] w;
    logic [7:0]  rd_exp[6];

    repeat (3) @(posedge clk);
    #1;
    check("rst tx_valid", tx_valid, 0);
    check("rst tx_data", tx_data, 0);
    check("rst we", inst_mem_we, 0);
    check("rst re", inst_mem_re, 0);
    check("rst busy", loader_busy, 0);
    check("rst overrun", rx_overrun, 0);
    check("rst re_addr", inst_mem_re_addr, 0);
    check("rst wr_addr", inst_mem_wr_addr, 0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Single-word write.
    clear_logs();
    send(8'h5A);
    check("wr busy mid", loader_busy, 1);
    f = '{8'h01, 8'h00, 8'h10, 8'h01, 8'h78, 8'h56, 8'h34, 8'h12, 8'hDA};
    send_frame(f);
    wait_tx("wr", 1, 50);
    if (txq.size() > 0) check("wr ack", txq[0], 8'hA5);
    check("wr count", wrq.size(), 1);
    if (wrq.size() > 0) begin
      check("wr addr", wrq[0].a, 14'h0010);
      check("wr data", wrq[0].d, 32'h12345678);
    end
    check("wr busy end", loader_busy, 0);

    // Single-word readback.
    clear_logs();
    f = '{8'h5A, 8'h02, 8'h00, 8'h10, 8'h01, 8'hED};
    send_frame(f);
    wait_tx("rd", 6, 200);
    check("rd req count", req.size(), 1);
    if (req.size() > 0) check("rd re_addr", req[0], 16'h0040);
    rd_exp = '{8'hA5, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEC};
    for (int i = 0; i < 6; i++)
      if (i < txq.size()) check($sformatf("rd byte%0d", i), txq[i], rd_exp[i]);
    check("rd busy end", loader_busy, 0);

    // Bad checksum: write still lands, NAK returned.
    clear_logs();
    f = '{8'h5A, 8'h01, 8'h00, 8'h10, 8'h01, 8'h78, 8'h56, 8'h34, 8'h12, 8'hDB};
    send_frame(f);
    wait_tx("badcs", 1, 50);
    if (txq.size() > 0) check("badcs nak", txq[0], 8'hEE);
    check("badcs wr count", wrq.size(), 1);
    if (wrq.size() > 0) check("badcs wr addr", wrq[0].a, 14'h0010);

    // LEN=0 at the top address wraps; ACK held under backpressure.
    clear_logs();
    f = '{8'h5A, 8'h01, 8'h3F, 8'hFF, 8'h00};
    send_frame(f);
    sum = 8'h01 + 8'h3F + 8'hFF + 8'h00;
    for (int i = 0; i < 256; i++) begin
      w = {8'(i), ~8'(i), 8'hC3, 8'(i) ^ 8'h5A};
      for (int b = 0; b < 4; b++) begin
        sum = sum + w[8*b +: 8];
        send(w[8*b +: 8]);
      end
    end
    tx_ready = 1'b0;
    send(8'h00 - sum);
    for (int i = 0; i < 20 && !tx_valid; i++) begin
      @(posedge clk);
      #1;
    end
    send(8'h33);
    check("bp overrun", rx_overrun, 1);
    for (int i = 0; i < 10; i++) begin
      check("bp tx_valid", tx_valid, 1);
      check("bp tx_data", tx_data, 8'hA5);
      @(posedge clk);
      #1;
    end
    check("bp busy held", loader_busy, 1);
    tx_ready = 1'b1;
    wait_tx("wrap", 1, 20);
    if (txq.size() > 0) check("wrap ack", txq[0], 8'hA5);
    check("wrap busy end", loader_busy, 0);
    check("wrap wr count", wrq.size(), 256);
    if (wrq.size() == 256) begin
      check("wrap addr0", wrq[0].a, 14'h3FFF);
      check("wrap addr1", wrq[1].a, 14'h0000);
      check("wrap addr255", wrq[255].a, 14'h00FE);
      check("wrap data1", wrq[1].d, 32'h01FEC35B);
      check("wrap data255", wrq[255].d, 32'hFF00C3A5);
    end

    // Garbage then bad command.
    clear_logs();
    send(8'h00);
    send(8'hFF);
    check("garbage busy", loader_busy, 0);
    check("garbage tx", txq.size(), 0);
    send(8'h5A);
    check("sync clears overrun", rx_overrun, 0);
    send(8'h07);
    wait_tx("badcmd", 1, 20);
    if (txq.size() > 0) check("badcmd nak", txq[0], 8'hEE);
    check("badcmd busy end", loader_busy, 0);
    check("badcmd no write", wrq.size(), 0);
    check("badcmd no read", req.size(), 0);

    // Reset mid-frame aborts silently.
    clear_logs();
    f = '{8'h5A, 8'h01, 8'h00};
    send_frame(f);
    reset_n = 1'b0;
    #1;
    check("abort busy", loader_busy, 0);
    check("abort tx_valid", tx_valid, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("abort no tx", txq.size(), 0);

    // Inter-byte timeout.
    clear_logs();
    send(8'h5A);
    send(8'h01);
    repeat (110) @(posedge clk);
    #1;
`ifdef FP51_LOADER_TIMEOUT_EN
    check("to tx count", txq.size(), 1);
    if (txq.size() > 0) check("to nak", txq[0], 8'hEE);
    check("to busy", loader_busy, 0);
`else
    check("noto tx count", txq.size(), 0);
    check("noto busy", loader_busy, 1);
    f = '{8'h00, 8'h10, 8'h01, 8'h78, 8'h56, 8'h34, 8'h12, 8'hDA};
    send_frame(f);
    wait_tx("noto", 1, 50);
    if (txq.size() > 0) check("noto ack", txq[0], 8'hA5);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
